onehot_seq_decoder: RTL and testbench



---
 rtl/onehot_seq_decoder.sv | 91 +++++++++
 tb/tb_onehot_seq_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_seq_decoder.sv
// rtl/onehot_seq_decoder.sv - registered SEL_W-to-2^SEL_W one-hot decoder with valid/ready and sweep mode
// Optional sweep mode is built in when DECODER_SWEEP_EN is defined.
module onehot_seq_decoder #(
  parameter int SEL_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_mode,
  input  logic [SEL_W-1:0]   in_last_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [(1<<SEL_W)-1:0] out_onehot,
  output logic [SEL_W-1:0]   out_index,
  output logic               busy
);

  localparam int OUT_W = 1 << SEL_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
`ifdef DECODER_SWEEP_EN
  localparam logic [1:0] ST_SWEEP = 2'd2;
`endif

  logic [1:0]       state;
  logic [1:0]       accept_state;
  logic [SEL_W-1:0] index_q;
  logic [OUT_W-1:0] onehot_q;
  logic [OUT_W-1:0] decoded;
  logic             accept;
  logic             beat_done;
  logic             sweep_step;

  assign out_valid  = (state != ST_IDLE);
  assign out_index  = index_q;
  assign out_onehot = onehot_q;
  assign beat_done  = out_valid && out_ready;
  assign accept     = in_valid && in_ready;
  assign decoded    = OUT_W'(1) << in_sel;

`ifdef DECODER_SWEEP_EN
  logic [SEL_W-1:0] last_q;

  assign in_ready     = (state != ST_SWEEP) && (!out_valid || out_ready);
  assign accept_state = in_mode ? ST_SWEEP : ST_HOLD;
  assign sweep_step   = (state == ST_SWEEP) && (index_q != last_q);
  assign busy         = (state == ST_SWEEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
    end else if (accept) begin
      last_q <= in_last_sel;
    end
  end
`else
  logic unused_sweep_inputs;

  assign in_ready            = !out_valid || out_ready;
  assign accept_state        = ST_HOLD;
  assign sweep_step          = 1'b0;
  assign busy                = 1'b0;
  assign unused_sweep_inputs = ^{in_mode, in_last_sel};
`endif

  // A new accept wins over retiring the current beat, so back-to-back beats have no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      index_q  <= '0;
      onehot_q <= '0;
    end else if (accept) begin
      state    <= accept_state;
      index_q  <= in_sel;
      onehot_q <= decoded;
    end else if (beat_done) begin
      if (sweep_step) begin
        index_q  <= index_q + SEL_W'(1);
        onehot_q <= {onehot_q[OUT_W-2:0], onehot_q[OUT_W-1]};
      end else begin
        state    <= ST_IDLE;
        index_q  <= '0;
        onehot_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_onehot_seq_decoder.sv
// tb/tb_onehot_seq_decoder.sv - scoreboard bench for onehot_seq_decoder
// Expectations follow DECODER_SWEEP_EN when it is defined for the build.
module tb_onehot_seq_decoder;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;
`ifdef DECODER_SWEEP_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             in_mode;
  logic [SEL_W-1:0] in_last_sel;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_onehot;
  logic [SEL_W-1:0] out_index;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [SEL_W-1:0] exp_q[$];

  onehot_seq_decoder #(.SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_mode(in_mode), .in_last_sel(in_last_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .out_index(out_index), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_expect(input logic [SEL_W-1:0] sel, input logic mode, input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0] k;
    if (SW && mode) begin
      k = sel;
      for (int n = 0; n < OUT_W; n++) begin
        exp_q.push_back(k);
        if (k == last) break;
        k = k + 3'd1;
      end
    end else begin
      exp_q.push_back(sel);
    end
  endtask

  // Leaves in_valid asserted on return so consecutive calls stream back-to-back.
  task automatic send(input logic [SEL_W-1:0] sel, input logic mode, input logic [SEL_W-1:0] last,
                      output int waits);
    bit taken;
    in_valid = 1'b1; in_sel = sel; in_mode = mode; in_last_sel = last;
    waits = 0;
    taken = 1'b0;
    while (!taken && waits <= 50) begin
      @(negedge clk);
      if (in_ready) taken = 1'b1;
      else waits++;
    end
    if (!taken) begin
      check_eq("accept_timeout", 64'(waits), 64'(0));
      in_valid = 1'b0;
    end else begin
      push_expect(sel, mode, last);
      @(posedge clk); #1;
      check_eq("lat_valid", 64'(out_valid), 64'(1));
      check_eq("lat_index", 64'(out_index), 64'(sel));
    end
  endtask

  task automatic release_in();
    in_valid = 1'b0; in_mode = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [SEL_W-1:0] e;
    if (mon_en && !rst) begin
      if (out_valid) begin
        check_eq("onehot_count", 64'($countones(out_onehot)), 64'(1));
        if (out_ready) begin
          check_eq("beat_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("beat_index", 64'(out_index), 64'(e));
            check_eq("beat_onehot", 64'(out_onehot), 64'(1) << e);
          end
        end
      end else begin
        check_eq("idle_onehot", 64'(out_onehot), 64'(0));
        check_eq("idle_index", 64'(out_index), 64'(0));
      end
      if (busy) check_eq("busy_ready", 64'(in_ready), 64'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int c0;
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_mode = 1'b0; in_last_sel = '0; out_ready = 1'b1;
    cycles(2);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check_eq("rst_valid", 64'(out_valid), 64'(0));
    check_eq("rst_onehot", 64'(out_onehot), 64'(0));
    check_eq("rst_index", 64'(out_index), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // back-to-back singles at full rate
    c0 = cyc;
    for (int i = 0; i < OUT_W; i++) begin
      send(3'(i), 1'b0, 3'd0, w);
      check_eq("b2b_waits", 64'(w), 64'(0));
    end
    release_in();
    check_eq("b2b_cycles", 64'(cyc - c0), 64'(OUT_W));
    cycles(2);

    // back-pressure hold, then replace on release
    out_ready = 1'b0;
    send(3'd5, 1'b0, 3'd0, w);
    in_sel = 3'd3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("hold_onehot", 64'(out_onehot), 64'h20);
      check_eq("hold_index", 64'(out_index), 64'(5));
      check_eq("hold_ready", 64'(in_ready), 64'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'd3, 1'b0, 3'd0, w);
    check_eq("release_waits", 64'(w), 64'(0));
    release_in();
    cycles(2);

    // sweep 2..5
    send(3'd2, 1'b1, 3'd5, w);
    release_in();
    for (int k = 0; k < 4; k++) begin
      check_eq("sweep_busy", 64'(busy), 64'(SW));
      check_eq("sweep_ready", 64'(in_ready), 64'(!SW));
      @(posedge clk); #1;
    end
    check_eq("sweep_end_busy", 64'(busy), 64'(0));
    check_eq("sweep_end_valid", 64'(out_valid), 64'(0));
    cycles(1);

    // wrapping sweep 6..1 with toggling back-pressure
    send(3'd6, 1'b1, 3'd1, w);
    release_in();
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    cycles(3);
    check_eq("wrap_valid", 64'(out_valid), 64'(0));
    check_eq("wrap_onehot", 64'(out_onehot), 64'(0));
    check_eq("wrap_drained", 64'(exp_q.size()), 64'(0));

    // single-beat sweep 3..3
    send(3'd3, 1'b1, 3'd3, w);
    release_in();
    check_eq("one_busy", 64'(busy), 64'(SW));
    check_eq("one_onehot", 64'(out_onehot), 64'h08);
    @(posedge clk); #1;
    check_eq("one_after_busy", 64'(busy), 64'(0));
    check_eq("one_after_valid", 64'(out_valid), 64'(0));
    cycles(1);

    // reset during third beat of full sweep 0..7
    send(3'd0, 1'b1, 3'd7, w);
    release_in();
    cycles(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check_eq("abort_valid", 64'(out_valid), 64'(0));
    check_eq("abort_onehot", 64'(out_onehot), 64'(0));
    check_eq("abort_busy", 64'(busy), 64'(0));
    check_eq("abort_ready", 64'(in_ready), 64'(1));
    send(3'd4, 1'b0, 3'd0, w);
    release_in();
    check_eq("post_rst_onehot", 64'(out_onehot), 64'h10);
    cycles(3);
    check_eq("final_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
